// File: rtl/spike_rate_display_if.sv
// Connection bundle between a spike source and the spike-rate display block.
// master drives the spike level and enable; slave returns the display outputs.
interface spike_rate_display_if;
    logic       ena;
    logic       spike_in;
    logic [6:0] segments;
    logic       overflow;
    logic       window_done;

    modport master (
        output ena,
        output spike_in,
        input  segments,
        input  overflow,
        input  window_done
    );

    modport slave (
        input  ena,
        input  spike_in,
        output segments,
        output overflow,
        output window_done
    );
endinterface

// File: rtl/spike_rate_display.sv
// Counts rising edges of spike_in over a gate window, latches the saturated count
// at window close and shows it as one hex digit; the decimal point flags saturation.
module spike_rate_display #(
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned CNT_WIDTH     = 4
) (
    input logic                 clk,
    input logic                 rst,
    spike_rate_display_if.slave bus
);

    localparam int unsigned WinWidth = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WinWidth-1:0]  WinLast = WinWidth'(WINDOW_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax  = {CNT_WIDTH{1'b1}};

    typedef enum logic {StCount, StLatch} state_e;

    state_e               state_q;
    logic [WinWidth-1:0]  win_cnt_q;
    logic [CNT_WIDTH-1:0] spk_cnt_q;
    logic [CNT_WIDTH-1:0] disp_val_q;
    logic                 spike_prev_q;
    logic                 ovf_acc_q;
    logic                 overflow_q;
    logic                 window_done_q;

    logic                 edge_det;
    logic                 cnt_at_max;
    logic [CNT_WIDTH-1:0] spk_cnt_inc;
    logic [3:0]           digit;
    logic [6:0]           seg;

    always_comb begin
        edge_det    = bus.spike_in & ~spike_prev_q;
        cnt_at_max  = (spk_cnt_q == CntMax);
        spk_cnt_inc = cnt_at_max ? spk_cnt_q : spk_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StCount;
            win_cnt_q     <= '0;
            spk_cnt_q     <= '0;
            disp_val_q    <= '0;
            spike_prev_q  <= 1'b0;
            ovf_acc_q     <= 1'b0;
            overflow_q    <= 1'b0;
            window_done_q <= 1'b0;
        end else if (!bus.ena) begin
            window_done_q <= 1'b0;
        end else begin
            spike_prev_q  <= bus.spike_in;
            window_done_q <= 1'b0;
            unique case (state_q)
                StCount: begin
                    if (edge_det) begin
                        spk_cnt_q <= spk_cnt_inc;
                        if (cnt_at_max) begin
                            ovf_acc_q <= 1'b1;
                        end
                    end
                    if (win_cnt_q == WinLast) begin
                        win_cnt_q <= '0;
                        state_q   <= StLatch;
                    end else begin
                        win_cnt_q <= win_cnt_q + WinWidth'(1);
                    end
                end
                StLatch: begin
                    // An edge landing in this cycle still belongs to the closing window.
                    disp_val_q    <= edge_det ? spk_cnt_inc : spk_cnt_q;
                    overflow_q    <= ovf_acc_q | (cnt_at_max & edge_det);
                    window_done_q <= 1'b1;
                    spk_cnt_q     <= '0;
                    ovf_acc_q     <= 1'b0;
                    win_cnt_q     <= '0;
                    state_q       <= StCount;
                end
                default: state_q <= StCount;
            endcase
        end
    end

    assign digit = 4'(disp_val_q);

    always_comb begin
        seg = 7'h3F;
        unique case (digit)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h3F;
        endcase
    end

    assign bus.segments    = seg;
    assign bus.overflow    = overflow_q;
    // Pulse is suppressed while paused so a frozen block never reports a window.
    assign bus.window_done = window_done_q & bus.ena;

endmodule

// File: tb/tb_spike_rate_display.sv
// Scoreboard bench for spike_rate_display: stimulus pushes expected {overflow,segments}
// per window; monitors pop and compare whenever window_done is seen.
module tb_spike_rate_display;

    logic clk;
    logic rst;

    spike_rate_display_if if16 ();
    spike_rate_display_if if64 ();

    spike_rate_display #(.WINDOW_CYCLES(16), .CNT_WIDTH(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    spike_rate_display #(.WINDOW_CYCLES(64), .CNT_WIDTH(4)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (if64)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp16_q[$];
    logic [7:0] exp64_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitors: sample away from the active edge, pop one expectation per pulse.
    always @(negedge clk) begin
        if (!rst && if16.window_done) begin
            if (exp16_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL win16_unexpected: window_done=1 with no window expected");
            end else begin
                check("win16_result", {1'b0, if16.overflow, if16.segments},
                      {1'b0, exp16_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if64.window_done) begin
            if (exp64_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL win64_unexpected: window_done=1 with no window expected");
            end else begin
                check("win64_result", {1'b0, if64.overflow, if64.segments},
                      {1'b0, exp64_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Leaves the bench 1 time unit after a posedge; the next posedge is window cycle 0.
    task automatic do_reset(input logic ena16, input logic ena64);
        @(negedge clk);
        #1;
        rst = 1'b1;
        if16.spike_in = 1'b0;
        if64.spike_in = 1'b0;
        if16.ena = ena16;
        if64.ena = ena64;
        repeat (2) @(posedge clk);
        #1;
        check("reset16", {if16.window_done, if16.overflow, if16.segments}, 9'h03F);
        check("reset64", {if64.window_done, if64.overflow, if64.segments}, 9'h03F);
        rst = 1'b0;
    endtask

    // One full 17-cycle window of dut16; pat[i] is the spike level at window cycle i.
    task automatic run_window16(input logic [16:0] pat);
        for (int i = 0; i < 17; i++) begin
            if16.spike_in = pat[i];
            @(posedge clk);
            #1;
        end
    endtask

    // One full 65-cycle window of dut64 with n one-cycle spikes every two cycles.
    task automatic run_window64(input int n);
        for (int i = 0; i < 65; i++) begin
            if64.spike_in = ((i % 2) == 0) && ((i / 2) < n);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [16:0] pat;
        rst = 1'b1;
        if16.ena = 1'b0;
        if16.spike_in = 1'b0;
        if64.ena = 1'b0;
        if64.spike_in = 1'b0;

        // 1) empty window
        do_reset(1'b1, 1'b0);
        exp16_q.push_back(8'h3F);
        run_window16(17'h00000);

        // 2) three single-cycle spikes
        do_reset(1'b1, 1'b0);
        exp16_q.push_back(8'h4F);
        run_window16(17'h00444);

        // 3) one long level counts once
        do_reset(1'b1, 1'b0);
        exp16_q.push_back(8'h06);
        run_window16(17'h01FF8);

        // 5) edge in the LATCH cycle belongs to the closing window
        do_reset(1'b1, 1'b0);
        exp16_q.push_back(8'h06);
        run_window16(17'h10000);
        exp16_q.push_back(8'h3F);
        run_window16(17'h00000);

        // 6a) reset mid-window discards the partial count and clears the display
        do_reset(1'b1, 1'b0);
        exp16_q.push_back(8'h4F);
        run_window16(17'h00444);
        pat = 17'h00155;
        for (int i = 0; i < 10; i++) begin
            if16.spike_in = pat[i];
            @(posedge clk);
            #1;
        end
        check("pre_reset_display", {if16.window_done, if16.overflow, if16.segments}, 9'h04F);
        rst = 1'b1;
        #1;
        check("async_reset_display", {if16.window_done, if16.overflow, if16.segments}, 9'h03F);
        do_reset(1'b1, 1'b0);
        exp16_q.push_back(8'h5B);
        run_window16(17'h00088);

        // 6b) a 40-cycle pause holds the window and ignores edges
        do_reset(1'b1, 1'b0);
        pat = 17'h02412;
        for (int i = 0; i < 8; i++) begin
            if16.spike_in = pat[i];
            @(posedge clk);
            #1;
        end
        if16.ena = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if16.spike_in = j[0];
            @(negedge clk);
            if (j % 8 == 0) begin
                check("paused_no_done", {8'h00, if16.window_done}, 9'h000);
            end
            @(posedge clk);
            #1;
        end
        if16.ena = 1'b1;
        exp16_q.push_back(8'h66);
        for (int i = 8; i < 17; i++) begin
            if16.spike_in = pat[i];
            @(posedge clk);
            #1;
        end

        // 4) saturation on the 64-cycle variant
        do_reset(1'b0, 1'b1);
        exp64_q.push_back(8'hF1);
        run_window64(20);
        exp64_q.push_back(8'h3F);
        run_window64(0);
        exp64_q.push_back(8'h71);
        run_window64(15);
        exp64_q.push_back(8'hF1);
        run_window64(16);

        repeat (3) @(negedge clk);
        check("queue16_drained", 9'(exp16_q.size()), 9'h000);
        check("queue64_drained", 9'(exp64_q.size()), 9'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
